// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: md_op encoding, default latencies and
// counter width. Also used by the decoder that generates md_op.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6
  } md_op_e;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;
  localparam int MD_CNT_W       = 6;

  // True for the operations that occupy the unit for several cycles.
  function automatic logic is_long_op(input logic [3:0] op);
    logic long_s;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: long_s = 1'b1;
      default:                            long_s = 1'b0;
    endcase
    return long_s;
  endfunction

endpackage

// File: rtl/md_unit.sv
// HI/LO multiply-divide unit. Results are computed in the issue cycle with
// single-cycle operators and held in pending registers; a down-counter only
// models the architectural latency before they are committed to HI/LO.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       md_op,
  input  logic             md_start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             md_stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [MD_CNT_W-1:0] CNT_ZERO  = MD_CNT_W'(0);
  localparam logic [MD_CNT_W-1:0] CNT_ONE   = MD_CNT_W'(1);
  localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);
  localparam logic [WIDTH-1:0]    W_ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]    W_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [MD_CNT_W-1:0] count_r;
  logic                busy_r;
  logic                pend_wr_r;
  logic [WIDTH-1:0]    hi_r;
  logic [WIDTH-1:0]    lo_r;
  logic [WIDTH-1:0]    pend_hi_r;
  logic [WIDTH-1:0]    pend_lo_r;

  logic [2*WIDTH-1:0]  prod_s;
  logic                signed_div_s;
  logic                div_by_zero_s;
  logic [WIDTH-1:0]    mag_a_s;
  logic [WIDTH-1:0]    mag_b_s;
  logic [WIDTH-1:0]    divisor_s;
  logic [WIDTH-1:0]    uquot_s;
  logic [WIDTH-1:0]    urem_s;
  logic [WIDTH-1:0]    quot_s;
  logic [WIDTH-1:0]    rem_s;

  // Product: sign-extend for MULT, zero-extend otherwise; the low 2*WIDTH
  // bits of the extended product are the correct signed/unsigned result.
  always_comb begin
    prod_s = {(2*WIDTH){1'b0}};
    if (md_op == MD_MULT) begin
      prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    end else begin
      prod_s = {W_ZERO, a} * {W_ZERO, b};
    end
  end

  // Quotient/remainder via magnitudes so signed division truncates toward
  // zero; most-negative / -1 falls out naturally as lo=a, hi=0.
  always_comb begin
    signed_div_s  = (md_op == MD_DIV);
    div_by_zero_s = (b == W_ZERO);
    mag_a_s       = a;
    mag_b_s       = b;
    if (signed_div_s && a[WIDTH-1]) begin
      mag_a_s = W_ZERO - a;
    end else begin
      mag_a_s = a;
    end
    if (signed_div_s && b[WIDTH-1]) begin
      mag_b_s = W_ZERO - b;
    end else begin
      mag_b_s = b;
    end
    if (div_by_zero_s) begin
      divisor_s = W_ONE;
    end else begin
      divisor_s = mag_b_s;
    end
    uquot_s = mag_a_s / divisor_s;
    urem_s  = mag_a_s % divisor_s;
    if (signed_div_s && (a[WIDTH-1] ^ b[WIDTH-1])) begin
      quot_s = W_ZERO - uquot_s;
    end else begin
      quot_s = uquot_s;
    end
    if (signed_div_s && a[WIDTH-1]) begin
      rem_s = W_ZERO - urem_s;
    end else begin
      rem_s = urem_s;
    end
  end

  // Issue, latency countdown, commit of pending results and direct HI/LO moves.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r   <= CNT_ZERO;
      busy_r    <= 1'b0;
      pend_wr_r <= 1'b0;
      hi_r      <= W_ZERO;
      lo_r      <= W_ZERO;
      pend_hi_r <= W_ZERO;
      pend_lo_r <= W_ZERO;
    end else if (busy_r) begin
      // Any md_start while busy is dropped here.
      count_r <= count_r - CNT_ONE;
      if (count_r == CNT_ONE) begin
        busy_r <= 1'b0;
        if (pend_wr_r) begin
          hi_r <= pend_hi_r;
          lo_r <= pend_lo_r;
        end
      end
    end else if (md_start) begin
      case (md_op)
        MD_MULT, MD_MULTU: begin
          pend_hi_r <= prod_s[2*WIDTH-1:WIDTH];
          pend_lo_r <= prod_s[WIDTH-1:0];
          pend_wr_r <= 1'b1;
          count_r   <= MULT_LOAD;
          busy_r    <= 1'b1;
        end
        MD_DIV, MD_DIVU: begin
          // Divide by zero still costs full latency but never commits.
          if (!div_by_zero_s) begin
            pend_hi_r <= rem_s;
            pend_lo_r <= quot_s;
          end
          pend_wr_r <= !div_by_zero_s;
          count_r   <= DIV_LOAD;
          busy_r    <= 1'b1;
        end
        MD_MTHI: hi_r <= a;
        MD_MTLO: lo_r <= a;
        default: begin
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign hi       = hi_r;
  assign lo       = lo_r;
  assign md_stall = busy_r | (md_start & is_long_op(md_op));

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus randomized
// operation streams compared against an arithmetic reference model.
module tb_md_unit;
  import md_pkg::*;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         md_start;
  logic [3:0]   md_op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         md_stall;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int vectors = 0;
  int errors  = 0;

  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk      (clk),
    .reset    (reset),
    .md_op    (md_op),
    .md_start (md_start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: {hi,lo} after the op completes, from plain arithmetic.
  function automatic logic [2*W-1:0] model_hilo(input logic [3:0] op,
                                                input logic [W-1:0] x,
                                                input logic [W-1:0] y);
    longint sx;
    longint sy;
    longint q;
    longint r;
    logic [2*W-1:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    res = {m_hi, m_lo};
    case (op)
      4'd1: begin
        q = sx * sy;
        res = q;
      end
      4'd2: res = {32'd0, x} * {32'd0, y};
      4'd3: begin
        if (y != 32'd0) begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
      4'd4: begin
        if (y != 32'd0) res = {x % y, x / y};
      end
      4'd5: res = {x, m_lo};
      4'd6: res = {m_hi, x};
      default: res = {m_hi, m_lo};
    endcase
    return res;
  endfunction

  function automatic int model_lat(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd2) return MC;
    if (op == 4'd3 || op == 4'd4) return DC;
    return 0;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      4: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one op, check stall/busy through its latency, then the result.
  // noise: 0 idle while busy, 1 fixed start (n_op,n_a), 2 random starts.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] x,
                       input logic [W-1:0] y, input int noise,
                       input logic [3:0] n_op, input logic [W-1:0] n_a);
    logic [2*W-1:0] exp_hl;
    int             lat;
    logic           exp_stall;
    exp_hl    = model_hilo(op, x, y);
    lat       = model_lat(op);
    exp_stall = (lat > 0);
    md_start = 1'b1;
    md_op    = op;
    a        = x;
    b        = y;
    #1;
    vectors++;
    if (md_stall !== exp_stall) begin
      errors++;
      $display("FAIL start_stall op=%0d got=%b want=%b", op, md_stall, exp_stall);
    end
    tick();
    for (int i = 0; i < lat; i++) begin
      if (noise == 1) begin
        md_start = 1'b1;
        md_op    = n_op;
        a        = n_a;
        b        = n_a;
      end else if (noise == 2) begin
        md_start = 1'($urandom_range(0, 1));
        md_op    = 4'($urandom_range(0, 15));
        a        = 32'($urandom);
        b        = 32'($urandom);
      end else begin
        md_start = 1'b0;
      end
      #1;
      vectors++;
      if ({busy, md_stall, hi, lo} !== {1'b1, 1'b1, m_hi, m_lo}) begin
        errors++;
        $display("FAIL busy_cycle op=%0d cyc=%0d got busy=%b stall=%b hi=%h lo=%h want busy=1 stall=1 hi=%h lo=%h",
                 op, i, busy, md_stall, hi, lo, m_hi, m_lo);
      end
      tick();
    end
    md_start = 1'b0;
    #1;
    vectors++;
    if ({busy, md_stall, hi, lo} !== {1'b0, 1'b0, exp_hl}) begin
      errors++;
      $display("FAIL commit op=%0d a=%h b=%h got busy=%b stall=%b hi=%h lo=%h want busy=0 stall=0 hi=%h lo=%h",
               op, x, y, busy, md_stall, hi, lo, exp_hl[63:32], exp_hl[31:0]);
    end
    {m_hi, m_lo} = exp_hl;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    md_start = 1'b1;
    md_op    = MD_MULT;
    a        = 32'($urandom);
    b        = 32'($urandom);
    tick();
    tick();
    reset    = 1'b0;
    md_start = 1'b0;
    md_op    = MD_NONE;
    m_hi     = 32'd0;
    m_lo     = 32'd0;
    for (int i = 0; i < MC + 2; i++) begin
      #1;
      vectors++;
      if ({busy, md_stall, hi, lo} !== {1'b0, 1'b0, 64'd0}) begin
        errors++;
        $display("FAIL reset_state cyc=%0d got busy=%b stall=%b hi=%h lo=%h want all zero",
                 i, busy, md_stall, hi, lo);
      end
      tick();
    end
  endtask

  task automatic test_mult_div_directed();
    do_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 0, MD_NONE, 32'd0);
    vectors++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
      errors++;
      $display("FAIL mult_neg2x3 got hi=%h lo=%h want hi=ffffffff lo=fffffffa", hi, lo);
    end
    do_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 0, MD_NONE, 32'd0);
    vectors++;
    if ({hi, lo} !== 64'h0000_0002_FFFF_FFFA) begin
      errors++;
      $display("FAIL multu_fffffffex3 got hi=%h lo=%h want hi=00000002 lo=fffffffa", hi, lo);
    end
    do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, MD_NONE, 32'd0);
    vectors++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      errors++;
      $display("FAIL div_neg7_2 got hi=%h lo=%h want hi=ffffffff lo=fffffffd", hi, lo);
    end
    do_op(MD_DIVU, 32'd7, 32'd2, 0, MD_NONE, 32'd0);
    vectors++;
    if ({hi, lo} !== 64'h0000_0001_0000_0003) begin
      errors++;
      $display("FAIL divu_7_2 got hi=%h lo=%h want hi=00000001 lo=00000003", hi, lo);
    end
  endtask

  task automatic test_mthi_while_busy();
    do_op(MD_MULT, 32'h0001_0000, 32'h0003_0000, 1, MD_MTHI, 32'h1234_5678);
    vectors++;
    if (hi !== 32'h0000_0003) begin
      errors++;
      $display("FAIL mthi_ignored got hi=%h want hi=00000003", hi);
    end
  endtask

  task automatic test_div_corners();
    do_op(MD_MTLO, 32'hA5A5_A5A5, 32'd0, 0, MD_NONE, 32'd0);
    do_op(MD_DIV, 32'd12345, 32'd0, 0, MD_NONE, 32'd0);
    vectors++;
    if (lo !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL div_by_zero got lo=%h want lo=a5a5a5a5", lo);
    end
    do_op(MD_DIVU, 32'hDEAD_BEEF, 32'd0, 0, MD_NONE, 32'd0);
    do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, MD_NONE, 32'd0);
    vectors++;
    if ({hi, lo} !== 64'h0000_0000_8000_0000) begin
      errors++;
      $display("FAIL div_min_by_neg1 got hi=%h lo=%h want hi=00000000 lo=80000000", hi, lo);
    end
  endtask

  task automatic test_undefined_ops();
    do_op(MD_NONE, 32'($urandom), 32'($urandom), 0, MD_NONE, 32'd0);
    for (int c = 7; c < 16; c++) begin
      do_op(4'(c), 32'($urandom), 32'($urandom), 0, MD_NONE, 32'd0);
    end
  endtask

  task automatic test_reset_abort();
    md_start = 1'b1;
    md_op    = MD_MULT;
    a        = 32'h0000_1234;
    b        = 32'h0001_0001;
    tick();
    md_start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    #1;
    vectors++;
    if ({busy, md_stall, hi, lo} !== {1'b0, 1'b0, 64'd0}) begin
      errors++;
      $display("FAIL abort_after_reset got busy=%b stall=%b hi=%h lo=%h want 0/0/0/0",
               busy, md_stall, hi, lo);
    end
    md_op    = MD_MULT;
    md_start = 1'b1;
    #1;
    vectors++;
    if (md_stall !== 1'b1) begin
      errors++;
      $display("FAIL abort_stall_follows_start got=%b want=1", md_stall);
    end
    md_start = 1'b0;
    tick();
    for (int i = 0; i < MC + 3; i++) begin
      vectors++;
      if ({busy, hi, lo} !== {1'b0, 64'd0}) begin
        errors++;
        $display("FAIL abort_no_commit cyc=%0d got busy=%b hi=%h lo=%h want 0/0/0",
                 i, busy, hi, lo);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back_random();
    logic [3:0] op;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        op = 4'($urandom_range(0, 15));
      end else begin
        op = 4'($urandom_range(1, 6));
      end
      do_op(op, pick_operand(), pick_operand(), 2, MD_NONE, 32'd0);
    end
  endtask

  initial begin
    reset    = 1'b1;
    md_start = 1'b0;
    md_op    = MD_NONE;
    a        = 32'd0;
    b        = 32'd0;
    m_hi     = 32'd0;
    m_lo     = 32'd0;
    tick();
    test_reset();
    test_mult_div_directed();
    test_mthi_while_busy();
    test_div_corners();
    test_undefined_ops();
    test_reset_abort();
    test_back_to_back_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
